mem_port_arbiter: RTL and testbench

- Shares the processor's single unified memory port between two requesters: instruction fetch (IF) and the load/store data path (D).
- Sits between the fetch/execute stages and memory inside top_level.
- Serialises one transaction at a time: grant, memory issue, fixed-latency wait, read-data return.
- Data accesses have priority. A starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between instruction
// fetch (IF) and the load/store data path (D). One transaction is in flight
// at a time: grant/issue, wait MEM_LAT cycles, then return read data.
// D has priority; a starvation counter forces an IF win after STARVE_MAX
// consecutive D grants made while IF was waiting.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   if_req/if_addr           fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata   fetch grant pulse, data-valid pulse, held data
//   d_req/d_we/d_addr/d_wdata   data request, held until d_gnt
//   d_gnt/d_rvalid/d_rdata   data grant pulse, completion pulse, held load data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory port
//   busy                     high whenever the arbiter is not idle
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    // Both MEM_LAT and STARVE_MAX are limited to 1..15.
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Latched copy of the granted request; drives the memory port directly.
    typedef struct packed {
        logic              owner_d;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } xact_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  lat_q, lat_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    xact_t             cur_q, cur_d;

    logic              if_gnt_d, d_gnt_d, mem_en_d;
    logic              if_rvalid_d, d_rvalid_d, busy_d;
    logic [DATA_W-1:0] if_rdata_d, d_rdata_d;

    logic              arb_ok, starve_hit, win_if, win_d, last_wait;

    // The memory port is the latched transaction itself.
    assign mem_we    = cur_q.we;
    assign mem_addr  = cur_q.addr;
    assign mem_wdata = cur_q.wdata;

    // Arbitration: allowed in IDLE and on the DONE-exit edge.
    always_comb begin
        arb_ok     = (state_q == IDLE) || (state_q == DONE);
        starve_hit = (starve_q == CNT_W'(STARVE_MAX));
        win_if     = arb_ok && if_req && (!d_req || starve_hit);
        win_d      = arb_ok && d_req && !win_if;
        last_wait  = (state_q == WAIT) && (lat_q == '0);
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        cur_d       = cur_q;
        if_rdata_d  = if_rdata;
        d_rdata_d   = d_rdata;
        if_gnt_d    = win_if;
        d_gnt_d     = win_d;
        mem_en_d    = win_if || win_d;
        if_rvalid_d = last_wait && !cur_q.owner_d;
        d_rvalid_d  = last_wait && cur_q.owner_d;

        case (state_q)
            IDLE: begin
                if (win_if || win_d) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                lat_d   = CNT_W'(MEM_LAT - 1);
            end
            WAIT: begin
                if (lat_q == '0) begin
                    state_d = DONE;
                end else begin
                    lat_d = CNT_W'(lat_q - 1'b1);
                end
            end
            DONE: begin
                state_d = (win_if || win_d) ? ISSUE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Capture the winner; an IF access is always a read.
        if (win_if) begin
            cur_d.owner_d = 1'b0;
            cur_d.we      = 1'b0;
            cur_d.addr    = if_addr;
            cur_d.wdata   = '0;
        end else if (win_d) begin
            cur_d.owner_d = 1'b1;
            cur_d.we      = d_we;
            cur_d.addr    = d_addr;
            cur_d.wdata   = d_wdata;
        end

        // Starvation: count D wins while IF waits, clear when IF wins or leaves.
        if (!if_req || win_if) begin
            starve_d = '0;
        end else if (win_d && !starve_hit) begin
            starve_d = CNT_W'(starve_q + 1'b1);
        end

        // Read data is captured on the edge that enters DONE; writes keep d_rdata.
        if (if_rvalid_d) begin
            if_rdata_d = mem_rdata;
        end
        if (d_rvalid_d && !cur_q.we) begin
            d_rdata_d = mem_rdata;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            lat_q     <= '0;
            starve_q  <= '0;
            cur_q     <= '0;
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            mem_en    <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            starve_q  <= starve_d;
            cur_q     <= cur_d;
            if_gnt    <= if_gnt_d;
            d_gnt     <= d_gnt_d;
            mem_en    <= mem_en_d;
            if_rvalid <= if_rvalid_d;
            d_rvalid  <= d_rvalid_d;
            if_rdata  <= if_rdata_d;
            d_rdata   <= d_rdata_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiter instances (MEM_LAT=2 and MEM_LAT=1), each
// with a requester agent, a fixed-latency memory model and a scoreboard of
// expected completions.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam bit STARVE_PAT [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    typedef struct {
        bit            is_d;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        bit            is_d;
        bit            we;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          if_req    [2];
    logic [AW-1:0] if_addr   [2];
    logic          if_gnt    [2];
    logic          if_rvalid [2];
    logic [DW-1:0] if_rdata  [2];
    logic          d_req     [2];
    logic          d_we      [2];
    logic [AW-1:0] d_addr    [2];
    logic [DW-1:0] d_wdata   [2];
    logic          d_gnt     [2];
    logic          d_rvalid  [2];
    logic [DW-1:0] d_rdata   [2];
    logic          mem_en    [2];
    logic          mem_we    [2];
    logic [AW-1:0] mem_addr  [2];
    logic [DW-1:0] mem_wdata [2];
    logic [DW-1:0] mem_rdata [2];
    logic          busy      [2];

    req_t          ifq [2][$];
    req_t          dq  [2][$];
    exp_t          sb  [2][$];
    bit            glog_d   [2][$];
    int            glog_cyc [2][$];
    int            rlog_cyc [2][$];
    req_t          cur_if [2];
    req_t          cur_d  [2];
    logic [DW-1:0] last_if [2];
    logic [DW-1:0] last_d  [2];
    logic [DW-1:0] shadow [int];
    logic [DW-1:0] memm   [int];
    int            age [2];
    logic          pw  [2];
    logic [AW-1:0] pa  [2];

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;
    int c0;
    int n;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2), .STARVE_MAX(4)) u_dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
        .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
        .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int g);
        return (g == 0) ? 2 : 1;
    endfunction

    function automatic int key(input int g, input logic [AW-1:0] a);
        return g * 65536 + int'(a);
    endfunction

    function automatic logic [DW-1:0] shadow_rd(input int g, input logic [AW-1:0] a);
        if (shadow.exists(key(g, a))) return shadow[key(g, a)];
        return a ^ 16'h5A5A;
    endfunction

    function automatic logic [DW-1:0] mem_rd(input int g, input logic [AW-1:0] a);
        if (memm.exists(key(g, a))) return memm[key(g, a)];
        return a ^ 16'h5A5A;
    endfunction

    function automatic req_t mk(input bit is_d, input bit we, input logic [AW-1:0] a,
                                input logic [DW-1:0] w);
        req_t r;
        r.is_d  = is_d;
        r.we    = we;
        r.addr  = a;
        r.wdata = w;
        return r;
    endfunction

    // Memory model: read data valid only in the cycle MEM_LAT after mem_en.
    always begin
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            if (!rst) begin
                age[g]       = -1;
                pw[g]        = 1'b0;
                pa[g]        = '0;
                mem_rdata[g] = 16'hDEAD;
            end else begin
                if (mem_en[g]) begin
                    age[g] = 0;
                    pa[g]  = mem_addr[g];
                    pw[g]  = mem_we[g];
                    if (mem_we[g]) memm[key(g, mem_addr[g])] = mem_wdata[g];
                end else if (age[g] >= 0 && age[g] < 64) begin
                    age[g]++;
                end
                mem_rdata[g] = (age[g] == lat_of(g) && !pw[g]) ? mem_rd(g, pa[g]) : 16'hDEAD;
            end
        end
    end

    // Requester agents and scoreboard, sampled 1 time unit after each rising edge.
    always begin
        exp_t e;
        bit   gnt_any;
        @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            if (!rst) begin
                if_req[g]  = 1'b0;
                if_addr[g] = '0;
                d_req[g]   = 1'b0;
                d_we[g]    = 1'b0;
                d_addr[g]  = '0;
                d_wdata[g] = '0;
                last_if[g] = '0;
                last_d[g]  = '0;
                sb[g].delete();
            end else begin
                gnt_any = if_gnt[g] | d_gnt[g];
                check("gnt_excl", 32'(if_gnt[g] & d_gnt[g]), 32'd0);
                check("rvalid_excl", 32'(if_rvalid[g] & d_rvalid[g]), 32'd0);
                check("busy", 32'(busy[g]), 32'(sb[g].size() != 0 || gnt_any));
                check("mem_en", 32'(mem_en[g]), 32'(gnt_any));

                if (if_rvalid[g] || d_rvalid[g]) begin
                    rlog_cyc[g].push_back(cyc);
                    if (sb[g].size() == 0) begin
                        check("rvalid_unexpected", 32'(if_rvalid[g] | d_rvalid[g]), 32'd0);
                    end else begin
                        e = sb[g].pop_front();
                        check("rvalid_owner", 32'(d_rvalid[g]), 32'(e.is_d));
                        check("rvalid_cycle", cyc, e.cyc);
                        if (!e.is_d) last_if[g] = e.data;
                        else if (!e.we) last_d[g] = e.data;
                    end
                end
                check("if_rdata", 32'(if_rdata[g]), 32'(last_if[g]));
                check("d_rdata", 32'(d_rdata[g]), 32'(last_d[g]));

                if (if_gnt[g]) begin
                    check("if_gnt_req", 32'(if_req[g]), 32'd1);
                    check("if_mem_addr", 32'(mem_addr[g]), 32'(cur_if[g].addr));
                    check("if_mem_we", 32'(mem_we[g]), 32'd0);
                    e.is_d = 1'b0;
                    e.we   = 1'b0;
                    e.data = shadow_rd(g, cur_if[g].addr);
                    e.cyc  = cyc + lat_of(g) + 1;
                    sb[g].push_back(e);
                    glog_d[g].push_back(1'b0);
                    glog_cyc[g].push_back(cyc);
                    if_req[g] = 1'b0;
                end
                if (d_gnt[g]) begin
                    check("d_gnt_req", 32'(d_req[g]), 32'd1);
                    check("d_mem_addr", 32'(mem_addr[g]), 32'(cur_d[g].addr));
                    check("d_mem_we", 32'(mem_we[g]), 32'(cur_d[g].we));
                    if (cur_d[g].we) begin
                        check("d_mem_wdata", 32'(mem_wdata[g]), 32'(cur_d[g].wdata));
                        shadow[key(g, cur_d[g].addr)] = cur_d[g].wdata;
                    end
                    e.is_d = 1'b1;
                    e.we   = cur_d[g].we;
                    e.data = shadow_rd(g, cur_d[g].addr);
                    e.cyc  = cyc + lat_of(g) + 1;
                    sb[g].push_back(e);
                    glog_d[g].push_back(1'b1);
                    glog_cyc[g].push_back(cyc);
                    d_req[g] = 1'b0;
                end

                // Next queued request goes out in the same cycle as the grant.
                if (!if_req[g] && ifq[g].size() != 0) begin
                    cur_if[g]  = ifq[g].pop_front();
                    if_req[g]  = 1'b1;
                    if_addr[g] = cur_if[g].addr;
                end
                if (!d_req[g] && dq[g].size() != 0) begin
                    cur_d[g]   = dq[g].pop_front();
                    d_req[g]   = 1'b1;
                    d_we[g]    = cur_d[g].we;
                    d_addr[g]  = cur_d[g].addr;
                    d_wdata[g] = cur_d[g].wdata;
                end
            end
        end
    end

    task automatic drain(input int g, input int max_cyc);
        int k = 0;
        while ((ifq[g].size() != 0 || dq[g].size() != 0 || if_req[g] || d_req[g] ||
                sb[g].size() != 0) && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        check("drain", 32'(ifq[g].size() + dq[g].size() + sb[g].size() +
                           int'(if_req[g]) + int'(d_req[g])), 32'd0);
        @(negedge clk);
    endtask

    task automatic clear_logs();
        for (int g = 0; g < 2; g++) begin
            glog_d[g].delete();
            glog_cyc[g].delete();
            rlog_cyc[g].delete();
        end
    endtask

    task automatic chk_zero(input int g);
        check("zero_if_gnt", 32'(if_gnt[g]), 32'd0);
        check("zero_if_rvalid", 32'(if_rvalid[g]), 32'd0);
        check("zero_if_rdata", 32'(if_rdata[g]), 32'd0);
        check("zero_d_gnt", 32'(d_gnt[g]), 32'd0);
        check("zero_d_rvalid", 32'(d_rvalid[g]), 32'd0);
        check("zero_d_rdata", 32'(d_rdata[g]), 32'd0);
        check("zero_mem_en", 32'(mem_en[g]), 32'd0);
        check("zero_mem_we", 32'(mem_we[g]), 32'd0);
        check("zero_mem_addr", 32'(mem_addr[g]), 32'd0);
        check("zero_mem_wdata", 32'(mem_wdata[g]), 32'd0);
        check("zero_busy", 32'(busy[g]), 32'd0);
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero(0);
        chk_zero(1);
        rst = 1'b1;

        // Fetch read returning 0xABCD.
        shadow[key(0, 16'h0010)] = 16'hABCD;
        memm[key(0, 16'h0010)]   = 16'hABCD;
        @(negedge clk);
        clear_logs();
        c0 = cyc;
        ifq[0].push_back(mk(1'b0, 1'b0, 16'h0010, 16'h0000));
        drain(0, 40);
        check("t1_ngnt", 32'(glog_cyc[0].size()), 32'd1);
        check("t1_owner", 32'(glog_d[0][0]), 32'd0);
        check("t1_gnt_cyc", glog_cyc[0][0], c0 + 2);
        check("t1_rv_cyc", rlog_cyc[0][0], c0 + 5);
        repeat (3) @(negedge clk);
        check("t1_hold", 32'(if_rdata[0]), 32'h0000ABCD);

        // Simultaneous requests: D first, then IF straight from DONE.
        clear_logs();
        c0 = cyc;
        dq[0].push_back(mk(1'b1, 1'b0, 16'h0040, 16'h0000));
        ifq[0].push_back(mk(1'b0, 1'b0, 16'h0050, 16'h0000));
        drain(0, 60);
        check("t2_first_d", 32'(glog_d[0][0]), 32'd1);
        check("t2_d_cyc", glog_cyc[0][0], c0 + 2);
        check("t2_d_rv", rlog_cyc[0][0], c0 + 5);
        check("t2_second_if", 32'(glog_d[0][1]), 32'd0);
        check("t2_if_cyc", glog_cyc[0][1], c0 + 6);

        // Starvation: both requesters held busy.
        clear_logs();
        for (int i = 0; i < 6; i++) dq[0].push_back(mk(1'b1, 1'b0, 16'h0100 + 16'(i), 16'h0000));
        for (int i = 0; i < 2; i++) ifq[0].push_back(mk(1'b0, 1'b0, 16'h0200 + 16'(i), 16'h0000));
        drain(0, 200);
        check("t3_ngnt", 32'(glog_d[0].size()), 32'd8);
        for (int i = 0; i < 8; i++) check("t3_order", 32'(glog_d[0][i]), 32'(STARVE_PAT[i]));
        for (int i = 1; i < 8; i++) check("t3_gap", glog_cyc[0][i] - glog_cyc[0][i-1], 32'd4);
        check("t3_last_d", 32'(d_rdata[0]), 32'(16'h0105 ^ 16'h5A5A));

        // Write leaves d_rdata alone; read it back afterwards.
        clear_logs();
        c0 = cyc;
        dq[0].push_back(mk(1'b1, 1'b1, 16'h0020, 16'h1234));
        drain(0, 40);
        check("t4_owner", 32'(glog_d[0][0]), 32'd1);
        check("t4_rv_cyc", rlog_cyc[0][0], c0 + 5);
        check("t4_rdata_keep", 32'(d_rdata[0]), 32'(16'h0105 ^ 16'h5A5A));
        dq[0].push_back(mk(1'b1, 1'b0, 16'h0020, 16'h0000));
        drain(0, 40);
        check("t4_readback", 32'(d_rdata[0]), 32'h00001234);

        // Reset during WAIT abandons the fetch.
        clear_logs();
        ifq[0].push_back(mk(1'b0, 1'b0, 16'h0030, 16'h0000));
        n = 0;
        while (glog_cyc[0].size() == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_gnt_seen", 32'(glog_cyc[0].size()), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_zero(0);
        for (int g = 0; g < 2; g++) begin
            ifq[g].delete();
            dq[g].delete();
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("t5_quiet", 32'(if_rvalid[0] | d_rvalid[0] | mem_en[0] | busy[0]), 32'd0);
        end
        check("t5_rdata", 32'(if_rdata[0]), 32'd0);

        // MEM_LAT=1 back-to-back fetches.
        clear_logs();
        c0 = cyc;
        ifq[1].push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000));
        ifq[1].push_back(mk(1'b0, 1'b0, 16'h0001, 16'h0000));
        drain(1, 40);
        check("t6_ngnt", 32'(glog_cyc[1].size()), 32'd2);
        check("t6_gnt_cyc", glog_cyc[1][0], c0 + 2);
        check("t6_rv_cyc", rlog_cyc[1][0], c0 + 4);
        check("t6_gnt_gap", glog_cyc[1][1] - glog_cyc[1][0], 32'd3);
        check("t6_rv_gap", rlog_cyc[1][1] - rlog_cyc[1][0], 32'd3);
        check("t6_rdata", 32'(if_rdata[1]), 32'(16'h0001 ^ 16'h5A5A));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
